pill_time_entry: RTL and testbench
==================================

# pill_time_entry

Keypad entry controller for the pill-box alarm schedule. It sits between the 4x4 keypad scanner, which delivers a 5-bit key code with 16 meaning "no key", and the alarm-slot register file. The block sequences a slot-select plus HH:MM entry, validates the time, and writes it to the register file through a valid/ready handshake. It also exports entry state and BCD digits for the display driver.

## Interface
- N_SLOTS, 4: number of alarm slots; legal range 1..9; selected with digit keys 1..N_SLOTS.
- TIMEOUT_CYC, 500_000_000: inactivity timeout in clock cycles, which is 10 s at 50 MHz; 29-bit counter.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- keyvalue  input  5  scanner key code; 0..15 means a key is pressed; 16 means no key.
- wr_ready  input  1  register file accepts a write.
- wr_valid  output  1  write request.
- wr_slot  output  4  slot index, 0-based.
- wr_hour  output  5  hour, 0..23.
- wr_min  output  6  minute, 0..59.
- state  output  3  FSM state encoding.
- slot  output  4  currently selected slot, 0-based.
- digits  output  16  BCD digits {H1,H0,M1,M0}.
- digit_cnt  output  3  number of digits entered, 0..4.
- busy  output  1  high when state is not IDLE.
- err  output  1  high while in ERROR.
- timeout  output  1  one-cycle pulse on an inactivity abort.

## Operation
- Key event:
  - kv_prev register, reset to 16, loaded with keyvalue every cycle.
  - key_evt = (keyvalue != 16) && (keyvalue != kv_prev).
  - A held key produces exactly one event; a direct change from one code to another also produces an event.
- Key map:
  - 0..9: digits.
  - 10 (A): start.
  - 11 (B): backspace.
  - 12 (C): cancel.
  - 13 (D): confirm.
  - 14, 15: ignored in all states.
- States: IDLE=0, SLOT=1, DIGITS=2, CHECK=3, WRITE=4, ERROR=5.
- IDLE:
  - A goes to SLOT.
  - All other keys are ignored.
- SLOT:
  - Digit d with 1 <= d <= N_SLOTS: slot = d-1, digit_cnt = 0, digits = 0, go to DIGITS.
  - C goes to IDLE.
  - Any other key, including an out-of-range digit, is ignored.
- DIGITS:
  - Digit key with digit_cnt < 4: the digit is written into position digit_cnt (0 = H1 ... 3 = M0), then digit_cnt increments.
  - Digit key with digit_cnt == 4: ignored.
  - B with digit_cnt > 0: digit_cnt decrements and that position is cleared to 0. B with digit_cnt == 0: no-op.
  - C goes to IDLE.
  - D with digit_cnt == 4 goes to CHECK; D with digit_cnt < 4 goes to ERROR.
- CHECK lasts exactly one cycle:
  - hour = H1*10 + H0 and min = M1*10 + M0, both computed at 7-bit width.
  - hour < 24 and min < 60: load wr_hour/wr_min (truncated to 5 and 6 bits), set wr_slot = slot, go to WRITE.
  - Otherwise go to ERROR.
- WRITE:
  - wr_valid = 1; wr_slot, wr_hour and wr_min are held stable.
  - Keys are ignored, including C.
  - The cycle where wr_valid && wr_ready completes the write: next state IDLE, digits and digit_cnt cleared.
- ERROR:
  - err = 1.
  - C goes to IDLE.
  - Any other key event returns to DIGITS with digit_cnt = 0 and digits = 0; slot is kept.
- IDLE entry from any path clears digits and digit_cnt; slot keeps its last value.

## Timing
- Reset values: state = IDLE, slot 0, digits 0, digit_cnt 0, wr_valid 0, wr_slot 0, wr_hour 0, wr_min 0, busy 0, err 0, timeout 0, kv_prev 16.
- All outputs are registered, except busy and err, which are decodes of the state register.
- A key event is acted on at the first clock edge where keyvalue holds the new code; the new state is visible on the next cycle.
- D with a valid entry:
  - CHECK for 1 cycle, then wr_valid is high from the 2nd cycle after the D edge.
  - With wr_ready tied high, wr_valid is high for exactly 1 cycle.
- wr_valid, once asserted, stays high until accepted; a minimum of 1 cycle.
- Reset mid-write drops wr_valid immediately, because reset is asynchronous.

## Configuration
- ENTRY_TIMEOUT_EN defined:
  - A 29-bit counter runs in SLOT, DIGITS and ERROR.
  - The counter clears on every key_evt and on every state change.
  - On reaching TIMEOUT_CYC-1: go to IDLE and pulse timeout for 1 cycle.
  - CHECK and WRITE are never timed out.
- ENTRY_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and entry waits indefinitely.

## Test plan
- Keys A, 2, 0, 8, 3, 0, D with wr_ready = 1 -> wr_valid 1-cycle pulse with wr_slot = 1, wr_hour = 8, wr_min = 30; state returns to IDLE.
- Keys A, 1, 2, 5, 0, 0, D -> ERROR with err = 1, no wr_valid; then key 0 -> DIGITS with digit_cnt = 0 and slot = 0.
- Keys A, 1, 1, 2, B, 3, 4, 5, D -> write of hour = 13, min = 45; digit_cnt sequence 1, 2, 1, 2, 3, 4.
- Keys A, 1, 2, 3, 5, 9, D with wr_ready held low for 5 cycles -> wr_valid held 6 cycles with fields stable; C pressed during WRITE is ignored.
- Key held at 5 for 1000 cycles in DIGITS -> exactly one digit stored; code change 5 -> 6 without an intervening 16 -> second digit stored.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYC = 100: A then no keys -> after 100 cycles in SLOT, timeout pulse and state IDLE; without the macro, state stays SLOT.

Source files
------------

// File: rtl/pill_time_entry.sv
// -----------------------------------------------------------------------------
// pill_time_entry
//
// Keypad entry controller for the pill-box alarm schedule. It turns scanner
// key codes into a slot select followed by an HH:MM entry, range-checks the
// time and hands it to the alarm-slot register file over a valid/ready
// handshake. Entry state and the BCD digits are exported for the display.
//
// Parameters
//    N_SLOTS      number of alarm slots (1..9), chosen with digit keys 1..N_SLOTS
//    TIMEOUT_CYC  inactivity timeout in clock cycles
//
// Ports
//    clk          system clock
//    rst          asynchronous active-high reset
//    keyvalue_i   scanner key code, 0..15 pressed, 16 = no key
//    wr_ready_i   register file accepts a write
//    wr_valid_o   write request, held until accepted
//    wr_slot_o    slot index of the write, 0-based
//    wr_hour_o    hour of the write, 0..23
//    wr_min_o     minute of the write, 0..59
//    state_o      FSM state (IDLE=0 SLOT=1 DIGITS=2 CHECK=3 WRITE=4 ERROR=5)
//    slot_o       currently selected slot, 0-based
//    digits_o     BCD digits {H1,H0,M1,M0}
//    digit_cnt_o  number of digits entered, 0..4
//    busy_o       state is not IDLE
//    err_o        state is ERROR
//    timeout_o    one-cycle pulse on an inactivity abort
//
// Build option
//    ENTRY_TIMEOUT_EN  when defined, an inactivity counter aborts SLOT, DIGITS
//                      and ERROR back to IDLE after TIMEOUT_CYC idle cycles.
//                      When undefined, no counter exists and timeout_o is 0.
// -----------------------------------------------------------------------------
module pill_time_entry #(
   parameter int N_SLOTS     = 4,
   parameter int TIMEOUT_CYC = 500_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  keyvalue_i,
   input  logic        wr_ready_i,
   output logic        wr_valid_o,
   output logic [3:0]  wr_slot_o,
   output logic [4:0]  wr_hour_o,
   output logic [5:0]  wr_min_o,
   output logic [2:0]  state_o,
   output logic [3:0]  slot_o,
   output logic [15:0] digits_o,
   output logic [2:0]  digit_cnt_o,
   output logic        busy_o,
   output logic        err_o,
   output logic        timeout_o
);

   localparam logic [4:0] KEY_NONE = 5'd16;
   localparam logic [4:0] KEY_A    = 5'd10;
   localparam logic [4:0] KEY_B    = 5'd11;
   localparam logic [4:0] KEY_C    = 5'd12;
   localparam logic [4:0] KEY_D    = 5'd13;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SLOT   = 3'd1,
      DIGITS = 3'd2,
      CHECK  = 3'd3,
      WRITE  = 3'd4,
      ERROR  = 3'd5
   } state_t;

   state_t      state_q;
   logic [4:0]  kv_prev_q;
   logic [3:0]  slot_q;
   logic [15:0] digits_q;
   logic [2:0]  digit_cnt_q;
   logic        wr_valid_q;
   logic [3:0]  wr_slot_q;
   logic [4:0]  wr_hour_q;
   logic [5:0]  wr_min_q;

   logic        key_evt;
   logic        key_is_digit;
   logic        key_is_slot;
   logic [15:0] digits_ins_d;   // digits with the pressed key stored at digit_cnt
   logic [15:0] digits_bs_d;    // digits with position digit_cnt-1 cleared
   logic [6:0]  hour_d;
   logic [6:0]  min_d;
   logic        to_hit;

   // A held key yields one event; a direct code-to-code change yields another.
   assign key_evt      = (keyvalue_i != KEY_NONE) && (keyvalue_i != kv_prev_q);
   assign key_is_digit = (keyvalue_i <= 5'd9);
   assign key_is_slot  = key_evt && (keyvalue_i != 5'd0) && (32'(keyvalue_i) <= N_SLOTS);

   // Position 0 (H1) sits in the top nibble, position 3 (M0) in the bottom.
   for (genvar gi = 0; gi < 4; gi++) begin : g_pos
      assign digits_ins_d[15-4*gi -: 4] = (digit_cnt_q == 3'(gi))   ? keyvalue_i[3:0]
                                                                    : digits_q[15-4*gi -: 4];
      assign digits_bs_d[15-4*gi -: 4]  = (digit_cnt_q == 3'(gi+1)) ? 4'd0
                                                                    : digits_q[15-4*gi -: 4];
   end

   assign hour_d = 7'(digits_q[15:12]) * 7'd10 + 7'(digits_q[11:8]);
   assign min_d  = 7'(digits_q[7:4])   * 7'd10 + 7'(digits_q[3:0]);

`ifdef ENTRY_TIMEOUT_EN
   logic [28:0] idle_cnt_q;
   logic        timeout_q;
   logic        timed_st;

   // Only the operator-facing states are timed; CHECK/WRITE always finish.
   // Every transition out of a timed state passes through a key event or a
   // non-timed state, so both clear conditions cover any state change.
   assign timed_st = (state_q == SLOT) || (state_q == DIGITS) || (state_q == ERROR);
   assign to_hit   = timed_st && !key_evt && (idle_cnt_q == 29'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= to_hit;
         if (!timed_st || key_evt || to_hit) idle_cnt_q <= '0;
         else                                idle_cnt_q <= idle_cnt_q + 29'd1;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign to_hit    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         kv_prev_q   <= KEY_NONE;
         slot_q      <= '0;
         digits_q    <= '0;
         digit_cnt_q <= '0;
         wr_valid_q  <= 1'b0;
         wr_slot_q   <= '0;
         wr_hour_q   <= '0;
         wr_min_q    <= '0;
      end else begin
         kv_prev_q <= keyvalue_i;
         if (to_hit) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            digit_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (key_evt && keyvalue_i == KEY_A) state_q <= SLOT;
               end
               SLOT: begin
                  if (key_is_slot) begin
                     slot_q      <= 4'(keyvalue_i - 5'd1);
                     digits_q    <= '0;
                     digit_cnt_q <= '0;
                     state_q     <= DIGITS;
                  end else if (key_evt && keyvalue_i == KEY_C) begin
                     digits_q    <= '0;
                     digit_cnt_q <= '0;
                     state_q     <= IDLE;
                  end
               end
               DIGITS: begin
                  if (key_evt) begin
                     if (key_is_digit) begin
                        if (digit_cnt_q != 3'd4) begin
                           digits_q    <= digits_ins_d;
                           digit_cnt_q <= digit_cnt_q + 3'd1;
                        end
                     end else if (keyvalue_i == KEY_B) begin
                        if (digit_cnt_q != 3'd0) begin
                           digits_q    <= digits_bs_d;
                           digit_cnt_q <= digit_cnt_q - 3'd1;
                        end
                     end else if (keyvalue_i == KEY_C) begin
                        digits_q    <= '0;
                        digit_cnt_q <= '0;
                        state_q     <= IDLE;
                     end else if (keyvalue_i == KEY_D) begin
                        state_q <= (digit_cnt_q == 3'd4) ? CHECK : ERROR;
                     end
                  end
               end
               CHECK: begin
                  if (hour_d < 7'd24 && min_d < 7'd60) begin
                     wr_slot_q  <= slot_q;
                     wr_hour_q  <= hour_d[4:0];
                     wr_min_q   <= min_d[5:0];
                     wr_valid_q <= 1'b1;
                     state_q    <= WRITE;
                  end else begin
                     state_q <= ERROR;
                  end
               end
               WRITE: begin
                  // Keys are deliberately ignored here so a write is never torn.
                  if (wr_ready_i) begin
                     wr_valid_q  <= 1'b0;
                     digits_q    <= '0;
                     digit_cnt_q <= '0;
                     state_q     <= IDLE;
                  end
               end
               ERROR: begin
                  if (key_evt && keyvalue_i == KEY_C) begin
                     digits_q    <= '0;
                     digit_cnt_q <= '0;
                     state_q     <= IDLE;
                  end else if (key_evt && keyvalue_i <= KEY_D) begin
                     digits_q    <= '0;
                     digit_cnt_q <= '0;
                     state_q     <= DIGITS;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign wr_valid_o  = wr_valid_q;
   assign wr_slot_o   = wr_slot_q;
   assign wr_hour_o   = wr_hour_q;
   assign wr_min_o    = wr_min_q;
   assign state_o     = state_q;
   assign slot_o      = slot_q;
   assign digits_o    = digits_q;
   assign digit_cnt_o = digit_cnt_q;
   assign busy_o      = (state_q != IDLE);
   assign err_o       = (state_q == ERROR);

endmodule

// File: tb/tb_pill_time_entry.sv
// -----------------------------------------------------------------------------
// tb_pill_time_entry
//
// Bench for pill_time_entry. A key-level reference model tracks the entry
// (mode, slot, digit list) and pushes each expected register-file write into
// a queue; an independent monitor pops and compares whenever a handshake
// completes. Directed sequences are followed by a randomized key stream.
// -----------------------------------------------------------------------------
module tb_pill_time_entry;

   localparam int NS = 4;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  keyvalue;
   logic        wr_ready;
   logic        wr_valid_o;
   logic [3:0]  wr_slot_o;
   logic [4:0]  wr_hour_o;
   logic [5:0]  wr_min_o;
   logic [2:0]  state_o;
   logic [3:0]  slot_o;
   logic [15:0] digits_o;
   logic [2:0]  digit_cnt_o;
   logic        busy_o;
   logic        err_o;
   logic        timeout_o;

   always #5 clk = ~clk;

   pill_time_entry #(.N_SLOTS(NS), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .keyvalue_i  (keyvalue),
      .wr_ready_i  (wr_ready),
      .wr_valid_o  (wr_valid_o),
      .wr_slot_o   (wr_slot_o),
      .wr_hour_o   (wr_hour_o),
      .wr_min_o    (wr_min_o),
      .state_o     (state_o),
      .slot_o      (slot_o),
      .digits_o    (digits_o),
      .digit_cnt_o (digit_cnt_o),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .timeout_o   (timeout_o)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct { int slot; int hour; int mn; } wr_t;
   wr_t sb_q[$];

   // Reference model: mode numbers are the externally visible state codes.
   int m_state, m_slot, m_cnt, m_prev;
   int m_dig[4];
   bit m_writing, m_chk_ok, hold_ready;
   int run_len, last_run, n_timeout;
   int held_slot, held_hour, held_min;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_digits();
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
   endtask

   function automatic int exp_digits();
      return (m_dig[0] << 12) | (m_dig[1] << 8) | (m_dig[2] << 4) | m_dig[3];
   endfunction

   task automatic model_key(input int k);
      int h, mn;
      case (m_state)
         0: if (k == 10) m_state = 1;
         1: begin
            if (k >= 1 && k <= NS) begin m_slot = k - 1; clear_digits(); m_state = 2; end
            else if (k == 12) begin clear_digits(); m_state = 0; end
         end
         2: begin
            if (k <= 9) begin
               if (m_cnt < 4) begin m_dig[m_cnt] = k; m_cnt++; end
            end else if (k == 11) begin
               if (m_cnt > 0) begin m_cnt--; m_dig[m_cnt] = 0; end
            end else if (k == 12) begin
               clear_digits(); m_state = 0;
            end else if (k == 13) begin
               if (m_cnt < 4) m_state = 5;
               else begin
                  h  = m_dig[0] * 10 + m_dig[1];
                  mn = m_dig[2] * 10 + m_dig[3];
                  m_chk_ok = (h < 24) && (mn < 60);
                  m_state = 3;
                  if (m_chk_ok) begin
                     sb_q.push_back('{slot: m_slot, hour: h, mn: mn});
                     m_writing = 1'b1;
                  end
               end
            end
         end
         5: begin
            if (k == 12) begin clear_digits(); m_state = 0; end
            else if (k <= 13) begin clear_digits(); m_state = 2; end
         end
         default: ;
      endcase
   endtask

   task automatic set_key(input int v);
      if (v != 16 && v != m_prev && !m_writing && m_state != 3) model_key(v);
      m_prev   = v;
      keyvalue = 5'(v);
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".state"},  int'(state_o),     m_state);
      chk({tag, ".slot"},   int'(slot_o),      m_slot);
      chk({tag, ".cnt"},    int'(digit_cnt_o), m_cnt);
      chk({tag, ".digits"}, int'(digits_o),    exp_digits());
      chk({tag, ".err"},    int'(err_o),       int'(m_state == 5));
      chk({tag, ".busy"},   int'(busy_o),      int'(m_state != 0));
      if (!m_writing) chk({tag, ".wr_valid"}, int'(wr_valid_o), 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (state_o == 3'd0) break;
         @(negedge clk);
      end
   endtask

   // One key press: drive the code for one cycle, release, check; a confirm
   // that reaches CHECK is followed through to ERROR or write completion.
   task automatic key(input int k, input string tag);
      @(negedge clk); set_key(k);
      @(negedge clk); set_key(16);
      check_state(tag);
      if (m_state == 3) begin
         @(negedge clk);
         if (m_chk_ok) begin
            chk({tag, ".write_state"}, int'(state_o),    4);
            chk({tag, ".write_valid"}, int'(wr_valid_o), 1);
            wait_idle();
            m_writing = 1'b0;
            m_state   = 0;
            clear_digits();
         end else begin
            m_state = 5;
         end
         check_state(tag);
      end
   endtask

   task automatic rand_key(output int k);
      int r;
      r = $urandom_range(0, 99);
      if      (r < 10) k = 10;
      else if (r < 15) k = 11;
      else if (r < 18) k = 12;
      else if (r < 27) k = 13;
      else if (r < 29) k = $urandom_range(14, 15);
      else if (r < 60) k = $urandom_range(0, 2);
      else             k = $urandom_range(0, 9);
   endtask

   // Ready driver: random acceptance unless a directed test holds it.
   always @(negedge clk) if (!hold_ready) wr_ready = 1'($urandom_range(0, 1));

   always @(negedge clk) if (timeout_o) n_timeout++;

   // Scoreboard monitor: inputs settle at the falling edge, so a sample just
   // after it sees exactly what the next rising edge will act on.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk); #1;
         if (!rst && wr_valid_o) begin
            if (run_len > 0) begin
               chk("wr_stable_slot", int'(wr_slot_o), held_slot);
               chk("wr_stable_hour", int'(wr_hour_o), held_hour);
               chk("wr_stable_min",  int'(wr_min_o),  held_min);
            end
            held_slot = int'(wr_slot_o);
            held_hour = int'(wr_hour_o);
            held_min  = int'(wr_min_o);
            run_len++;
            if (wr_ready) begin
               if (sb_q.size() == 0) chk("wr_unexpected", sb_q.size(), 1);
               else begin
                  e = sb_q.pop_front();
                  chk("wr_slot", int'(wr_slot_o), e.slot);
                  chk("wr_hour", int'(wr_hour_o), e.hour);
                  chk("wr_min",  int'(wr_min_o),  e.mn);
                  $display("write slot=%0d %0d:%0d run=%0d", e.slot, e.hour, e.mn, run_len);
               end
               last_run = run_len;
               run_len  = 0;
            end
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1; keyvalue = 5'd16; wr_ready = 1'b0; hold_ready = 1'b1;
      m_state = 0; m_slot = 0; m_prev = 16; m_writing = 0; m_chk_ok = 0;
      run_len = 0; last_run = 0; n_timeout = 0;
      clear_digits();
      repeat (3) @(negedge clk);
      chk("rst.state",    int'(state_o),     0);
      chk("rst.wr_valid", int'(wr_valid_o),  0);
      chk("rst.wr_slot",  int'(wr_slot_o),   0);
      chk("rst.wr_hour",  int'(wr_hour_o),   0);
      chk("rst.wr_min",   int'(wr_min_o),    0);
      chk("rst.slot",     int'(slot_o),      0);
      chk("rst.digits",   int'(digits_o),    0);
      chk("rst.cnt",      int'(digit_cnt_o), 0);
      chk("rst.busy",     int'(busy_o),      0);
      chk("rst.err",      int'(err_o),       0);
      chk("rst.timeout",  int'(timeout_o),   0);
      rst = 1'b0;

      // Valid entry, ready tied high: single-cycle write of slot 1, 08:30.
      wr_ready = 1'b1;
      key(10, "t1"); key(2, "t1"); key(0, "t1"); key(8, "t1");
      key(3, "t1");  key(0, "t1"); key(13, "t1");
      chk("t1.run_len", last_run, 1);

      // Hour 25 rejected, then any key returns to DIGITS.
      key(10, "t2"); key(1, "t2"); key(2, "t2"); key(5, "t2");
      key(0, "t2");  key(0, "t2"); key(13, "t2");
      key(0, "t2.recover");
      key(12, "t2.cancel");

      // Backspace mid-entry: 13:45 to slot 0.
      key(10, "t3"); key(1, "t3"); key(1, "t3"); key(2, "t3"); key(11, "t3");
      key(3, "t3");  key(4, "t3"); key(5, "t3"); key(13, "t3");

      // Ready withheld five cycles; C during WRITE must not abort the write.
      wr_ready = 1'b0;
      key(10, "t4"); key(1, "t4"); key(2, "t4"); key(3, "t4"); key(5, "t4"); key(9, "t4");
      fork
         key(13, "t4");
         begin
            for (int i = 0; i < 20 && !wr_valid_o; i++) @(negedge clk);
            set_key(12);
            @(negedge clk); set_key(16);
            repeat (4) @(negedge clk);
            wr_ready = 1'b1;
            @(negedge clk); wr_ready = 1'b0;
         end
      join
      chk("t4.run_len", last_run, 6);

      // Held key gives one digit; direct 5 -> 6 change gives a second.
      key(10, "t5"); key(3, "t5");
      @(negedge clk); set_key(5);
      repeat (1000) @(negedge clk);
      check_state("t5.hold");
      set_key(6);
      @(negedge clk);
      check_state("t5.change");
      set_key(16);
      key(12, "t5.cancel");

      // Asynchronous reset while a write is pending.
      key(10, "t6"); key(1, "t6"); key(1, "t6"); key(0, "t6"); key(0, "t6"); key(0, "t6");
      @(negedge clk); set_key(13);
      @(negedge clk); set_key(16);
      @(negedge clk);
      chk("t6.pre_valid", int'(wr_valid_o), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6.async_valid", int'(wr_valid_o), 0);
      chk("t6.async_state", int'(state_o),    0);
      @(negedge clk); rst = 1'b0;
      sb_q.delete();
      m_state = 0; m_slot = 0; m_writing = 0; run_len = 0;
      clear_digits();
      key(14, "t6.after");

      // Randomized key stream with random ready.
      hold_ready = 1'b0;
      for (int n = 0; n < 400; n++) begin
         rand_key(k);
         key(k, "rnd");
      end
      hold_ready = 1'b1; wr_ready = 1'b0;
      key(12, "rnd.cancel");
      key(12, "rnd.cancel2");

      // Inactivity in SLOT.
      n_timeout = 0;
      key(10, "t7");
      repeat (150) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
      chk("t7.timeouts", n_timeout, 1);
      m_state = 0;
      clear_digits();
`else
      chk("t7.timeouts", n_timeout, 0);
`endif
      check_state("t7");

      chk("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
